// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared state encoding and limits for the CPU run controller.
package cpu_run_pkg;

  // Largest number of cores one controller instance may sequence.
  localparam int unsigned RUN_CTRL_MAX_CORES = 8;

  // Run controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  // States in which a start request begins a fresh run.
  function automatic logic accepts_start(input run_state_e st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at its
// all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences a group of CPU cores through reset hold, run and
// completion, tracking run cycles and per-core halts.
// Optional watchdog: define RUN_CTRL_WATCHDOG_EN to abort a run into TIMEOUT
// after MAX_CYCLES run cycles; without it timeout stays 0.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned N_CORES    = 1,
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 10000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_CORES-1:0] halt_req,
  output logic [N_CORES-1:0] core_reset,
  output logic               running,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [N_CORES-1:0] halted
);

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  // Hold counter counts down to zero, so HOLD lasts exactly RST_CYCLES cycles.
  localparam logic [7:0]       HOLD_INIT = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT  = CNT_W'(MAX_CYCLES - 1);

  run_state_e         state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic [N_CORES-1:0] halted_q, halted_d;
  logic [N_CORES-1:0] core_reset_q, core_reset_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               ready_q;
  logic               start_ok;
  logic               wd_hit;
  logic               cnt_clr;
  logic               cnt_en;

  // ready_q is low on the first edge after reset release so a start there is dropped.
  assign start_ok = start & ready_q;
  assign wd_hit   = WD_EN & (cycle_cnt == WD_LIMIT);

  // Next-state, hold countdown, halt capture and cycle counter control.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    halted_d = halted_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start_ok && accepts_start(state_q)) begin
          state_d  = ST_HOLD;
          hold_d   = HOLD_INIT;
          halted_d = '0;
          cnt_clr  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (hold_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      ST_RUN: begin
        // The halt arriving this cycle counts toward completion, and DONE beats the watchdog.
        halted_d = halted_q | halt_req;
        if (&halted_d) begin
          state_d = ST_DONE;
        end else if (wd_hit) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_RUN;
          cnt_en  = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        halted_d = '0;
        cnt_clr  = 1'b1;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    core_reset_d = '1;
    running_d    = 1'b0;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    case (state_d)
      ST_RUN: begin
        // A core that has halted goes straight back into reset.
        core_reset_d = halted_d;
        running_d    = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      ST_TIMEOUT: begin
        timeout_d = WD_EN;
      end
      default: begin
        core_reset_d = '1;
      end
    endcase
  end

  // State, hold counter, halt flags and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= 8'd0;
      halted_q     <= '0;
      core_reset_q <= '1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      halted_q     <= halted_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      ready_q      <= 1'b1;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cycle_cnt)
  );

  assign core_reset = core_reset_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench for cpu_run_ctrl (2 cores, 3-cycle hold,
// 8-bit counter, watchdog limit 16 when RUN_CTRL_WATCHDOG_EN is defined).
module tb_cpu_run_ctrl;

  localparam int NC = 2;
  localparam int RC = 3;
  localparam int CW = 8;
  localparam int MC = 16;
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam int S_IDLE = 0;
  localparam int S_HOLD = 1;
  localparam int S_RUN  = 2;
  localparam int S_DONE = 3;
  localparam int S_TO   = 4;

  typedef struct packed {
    logic [1:0] cr;
    logic       run;
    logic       dn;
    logic       to;
    logic [7:0] cnt;
    logic [1:0] hlt;
  } obs_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [NC-1:0] halt_req;
  logic [NC-1:0] core_reset;
  logic          running;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_cnt;
  logic [NC-1:0] halted;

  int checks   = 0;
  int failures = 0;

  obs_t exp_q[$];

  // Reference model state
  int         m_st;
  int         m_hold;
  int         m_cnt;
  logic [1:0] m_halted;
  bit         m_ready;

  cpu_run_ctrl #(
    .N_CORES    (NC),
    .RST_CYCLES (RC),
    .CNT_W      (CW),
    .MAX_CYCLES (MC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .core_reset (core_reset),
    .running    (running),
    .done       (done),
    .timeout    (timeout),
    .cycle_cnt  (cycle_cnt),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_st     = S_IDLE;
    m_hold   = 0;
    m_cnt    = 0;
    m_halted = 2'b00;
    m_ready  = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic [1:0] h);
    logic [1:0] nh;
    case (m_st)
      S_IDLE, S_DONE, S_TO: begin
        if (s && m_ready) begin
          m_st     = S_HOLD;
          m_hold   = RC - 1;
          m_cnt    = 0;
          m_halted = 2'b00;
        end
      end
      S_HOLD: begin
        if (m_hold == 0) m_st = S_RUN;
        else m_hold = m_hold - 1;
      end
      S_RUN: begin
        nh = m_halted | h;
        if (nh == 2'b11) m_st = S_DONE;
        else if (WD && (m_cnt == MC - 1)) m_st = S_TO;
        else if (m_cnt < 255) m_cnt = m_cnt + 1;
        m_halted = nh;
      end
      default: m_st = S_IDLE;
    endcase
    m_ready = 1'b1;
  endtask

  function automatic obs_t model_obs();
    obs_t e;
    e.cr  = (m_st == S_RUN) ? m_halted : 2'b11;
    e.run = (m_st == S_RUN);
    e.dn  = (m_st == S_DONE);
    e.to  = (m_st == S_TO);
    e.cnt = 8'(m_cnt);
    e.hlt = m_halted;
    return e;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.cr  = core_reset;
    o.run = running;
    o.dn  = done;
    o.to  = timeout;
    o.cnt = cycle_cnt;
    o.hlt = halted;
    return o;
  endfunction

  // One clock: drive inputs at negedge, queue the model's expectation, compare after the edge.
  task automatic tick(input logic s, input logic [1:0] h, input string tag);
    obs_t e;
    obs_t o;
    @(negedge clk);
    start    = s;
    halt_req = h;
    model_step(s, h);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    o = dut_obs();
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL %s: actual cr=%b run=%b done=%b to=%b cnt=%0d halted=%b, expected cr=%b run=%b done=%b to=%b cnt=%0d halted=%b",
               tag, o.cr, o.run, o.dn, o.to, o.cnt, o.hlt, e.cr, e.run, e.dn, e.to, e.cnt, e.hlt);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    halt_req = 2'b00;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut_obs() !== obs_t'({2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00})) begin
      failures++;
      $display("FAIL reset_values: actual %b required 110000000000000", dut_obs());
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    // Start on the release edge must be dropped; halt outside RUN ignored too.
    tick(1'b1, 2'b11, "release_edge_start");
    checks++;
    if (core_reset !== 2'b11 || running !== 1'b0) begin
      failures++;
      $display("FAIL release_start_ignored: actual cr=%b run=%b required cr=11 run=0", core_reset, running);
    end
    for (int i = 0; i < 20; i++) tick(1'b0, 2'b00, "idle_hold");
    checks++;
    if (core_reset !== 2'b11 || cycle_cnt !== 8'd0 || running !== 1'b0) begin
      failures++;
      $display("FAIL idle_20: actual cr=%b cnt=%0d run=%b required cr=11 cnt=0 run=0", core_reset, cycle_cnt, running);
    end
  endtask

  task automatic test_hold_run();
    int n_hi;
    n_hi = 0;
    tick(1'b1, 2'b00, "start");
    for (int i = 0; i < 10 && core_reset === 2'b11; i++) begin
      n_hi++;
      tick(1'b0, 2'b00, "hold");
    end
    checks++;
    if (n_hi != RC) begin
      failures++;
      $display("FAIL hold_len: actual %0d required %0d", n_hi, RC);
    end
    checks++;
    if (running !== 1'b1 || cycle_cnt !== 8'd0) begin
      failures++;
      $display("FAIL first_run: actual run=%b cnt=%0d required run=1 cnt=0", running, cycle_cnt);
    end
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, 2'b00, "run_count");
      checks++;
      if (cycle_cnt !== 8'(i)) begin
        failures++;
        $display("FAIL run_inc: actual %0d required %0d", cycle_cnt, i);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut_obs() !== obs_t'({2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00})) begin
      failures++;
      $display("FAIL mid_run_reset: actual %b required 110000000000000", dut_obs());
    end
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    tick(1'b0, 2'b00, "post_reset");
    tick(1'b1, 2'b00, "restart");
    for (int i = 0; i < RC; i++) tick(1'b0, 2'b00, "rehold");
    checks++;
    if (running !== 1'b1 || cycle_cnt !== 8'd0 || halted !== 2'b00) begin
      failures++;
      $display("FAIL fresh_run: actual run=%b cnt=%0d halted=%b required run=1 cnt=0 halted=00", running, cycle_cnt, halted);
    end
  endtask

  task automatic test_halts();
    for (int i = 0; i < 20 && cycle_cnt !== 8'd5; i++) tick(1'b0, 2'b00, "to_cnt5");
    checks++;
    if (cycle_cnt !== 8'd5) begin
      failures++;
      $display("FAIL reach_cnt5: actual %0d required 5", cycle_cnt);
    end
    tick(1'b0, 2'b01, "halt0");
    checks++;
    if (halted !== 2'b01 || core_reset !== 2'b01 || running !== 1'b1) begin
      failures++;
      $display("FAIL halt0_set: actual halted=%b cr=%b run=%b required halted=01 cr=01 run=1", halted, core_reset, running);
    end
    for (int i = 0; i < 20 && cycle_cnt !== 8'd9; i++) tick(1'b0, 2'b00, "to_cnt9");
    tick(1'b0, 2'b10, "halt1");
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || halted !== 2'b11 || cycle_cnt !== 8'd9 || core_reset !== 2'b11) begin
      failures++;
      $display("FAIL all_halted: actual done=%b run=%b halted=%b cnt=%0d cr=%b required done=1 run=0 halted=11 cnt=9 cr=11",
               done, running, halted, cycle_cnt, core_reset);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 2'b00, "done_hold");
    checks++;
    if (cycle_cnt !== 8'd9 || done !== 1'b1) begin
      failures++;
      $display("FAIL done_frozen: actual cnt=%0d done=%b required cnt=9 done=1", cycle_cnt, done);
    end
  endtask

  task automatic test_no_halt();
    tick(1'b1, 2'b00, "restart_from_done");
    for (int i = 0; i < RC; i++) tick(1'b0, 2'b00, "hold2");
    for (int i = 0; i < 300; i++) tick(1'b0, 2'b00, "long_run");
`ifdef RUN_CTRL_WATCHDOG_EN
    checks++;
    if (timeout !== 1'b1 || running !== 1'b0 || cycle_cnt !== 8'd15 || core_reset !== 2'b11) begin
      failures++;
      $display("FAIL watchdog: actual to=%b run=%b cnt=%0d cr=%b required to=1 run=0 cnt=15 cr=11", timeout, running, cycle_cnt, core_reset);
    end
`else
    checks++;
    if (running !== 1'b1 || timeout !== 1'b0 || cycle_cnt !== 8'd255) begin
      failures++;
      $display("FAIL saturate: actual run=%b to=%b cnt=%0d required run=1 to=0 cnt=255", running, timeout, cycle_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 2'b11, "both_halt");
`ifdef RUN_CTRL_WATCHDOG_EN
    checks++;
    if (timeout !== 1'b1 || halted !== 2'b00) begin
      failures++;
      $display("FAIL halt_in_timeout: actual to=%b halted=%b required to=1 halted=00", timeout, halted);
    end
`else
    checks++;
    if (done !== 1'b1 || halted !== 2'b11 || cycle_cnt !== 8'd255) begin
      failures++;
      $display("FAIL both_halt_done: actual done=%b halted=%b cnt=%0d required done=1 halted=11 cnt=255", done, halted, cycle_cnt);
    end
`endif
    tick(1'b1, 2'b00, "restart3");
    checks++;
    if (cycle_cnt !== 8'd0 || halted !== 2'b00 || core_reset !== 2'b11) begin
      failures++;
      $display("FAIL restart_clear: actual cnt=%0d halted=%b cr=%b required cnt=0 halted=00 cr=11", cycle_cnt, halted, core_reset);
    end
    tick(1'b1, 2'b11, "start_halt_in_hold");
    tick(1'b0, 2'b00, "hold3");
    tick(1'b0, 2'b00, "enter_run");
    checks++;
    if (running !== 1'b1 || cycle_cnt !== 8'd0 || halted !== 2'b00) begin
      failures++;
      $display("FAIL hold_inputs_ignored: actual run=%b cnt=%0d halted=%b required run=1 cnt=0 halted=00", running, cycle_cnt, halted);
    end
    tick(1'b1, 2'b00, "start_in_run");
    checks++;
    if (running !== 1'b1 || cycle_cnt !== 8'd1) begin
      failures++;
      $display("FAIL start_in_run: actual run=%b cnt=%0d required run=1 cnt=1", running, cycle_cnt);
    end
    tick(1'b0, 2'b01, "early_halt0");
    for (int i = 0; i < 30 && cycle_cnt !== 8'd15; i++) tick(1'b0, 2'b00, "to_cnt15");
    tick(1'b0, 2'b10, "last_halt_at_limit");
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || cycle_cnt !== 8'd15) begin
      failures++;
      $display("FAIL done_wins: actual done=%b to=%b cnt=%0d required done=1 to=0 cnt=15", done, timeout, cycle_cnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hold_run();
    test_reset_mid_run();
    test_halts();
    test_no_halt();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded 100000 time units");
    $fatal(1, "time limit");
  end

endmodule
